// File: rtl/bayer_pattern_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : bayer_pattern_tx_if
// Description : RAW Bayer pixel stream, 4 x 16-bit pixels per beat.
// Revision    : 1.0 - initial release
// ============================================================================
interface bayer_pattern_tx_if;
    logic        line_valid;
    logic        data_valid;
    logic [63:0] data;

    modport master (output line_valid, data_valid, data);
    modport slave  (input  line_valid, data_valid, data);
endinterface
`default_nettype wire

// File: rtl/bayer_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : bayer_pattern_tx
// Description : Synthetic RAW Bayer frame source (bars / ramp / grey).
// Revision    : 1.0 - initial release
// ============================================================================
module bayer_pattern_tx #(
    parameter int          H_GROUPS   = 480,
    parameter int          V_LINES    = 1080,
    parameter int          H_BLANK    = 16,
    parameter int          V_BLANK    = 64,
    parameter int          BAR_GROUPS = 60,
    parameter logic [15:0] PIXEL_MAX  = 16'h03FF
) (
    input  wire logic              clk_i,
    input  wire logic              reset_i,
    input  wire logic              enable_i,
    input  wire logic [1:0]        pattern_sel_i,
    bayer_pattern_tx_if.master     tx,
    output logic                   frame_valid_o,
    output logic                   frame_start_o,
    output logic [15:0]            frame_count_o
);
    localparam int c_vb_w = $clog2(V_BLANK + 1);
    localparam int c_hb_w = $clog2(H_BLANK + 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_V_BLANK     = 3'd1,
        S_LINE_LEAD   = 3'd2,
        S_LINE_ACTIVE = 3'd3,
        S_H_BLANK     = 3'd4
    } state_t;

    state_t              r_state;
    logic [1:0]          r_sel;
    logic [c_vb_w-1:0]   r_vb_cnt;
    logic [c_hb_w-1:0]   r_hb_cnt;
    logic [11:0]         r_beat;
    logic [11:0]         r_line;
    logic [11:0]         r_bar_sub;
    logic [2:0]          r_bar;
    logic                r_line_valid;
    logic                r_data_valid;
    logic [63:0]         r_data;
    logic                r_frame_valid;
    logic                r_frame_start;
    logic [15:0]         r_frame_count;

    function automatic logic [63:0] f_beat(input logic [1:0]  sel,
                                           input logic [11:0] beat,
                                           input logic [2:0]  bar,
                                           input logic        odd);
        logic [2:0]  rgb;
        logic [15:0] px;
        logic        on;
        logic [63:0] v;
        v = '0;
        case (bar)
            3'd0:    rgb = 3'b111;
            3'd1:    rgb = 3'b110;
            3'd2:    rgb = 3'b011;
            3'd3:    rgb = 3'b010;
            3'd4:    rgb = 3'b101;
            3'd5:    rgb = 3'b100;
            3'd6:    rgb = 3'b001;
            default: rgb = 3'b000;
        endcase
        for (int k = 0; k < 4; k++) begin
            // Even lines carry R/G phases, odd lines G/B.
            if (!odd) on = k[0] ? rgb[1] : rgb[2];
            else      on = k[0] ? rgb[0] : rgb[1];
            case (sel)
                2'd1:    px = ({2'b00, beat, 2'b00} + 16'(k)) & PIXEL_MAX;
                2'd2:    px = PIXEL_MAX >> 1;
                default: px = on ? PIXEL_MAX : 16'h0000;
            endcase
            v[63-16*k -: 16] = px;
        end
        return v;
    endfunction

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state       <= S_IDLE;
            r_sel         <= '0;
            r_vb_cnt      <= '0;
            r_hb_cnt      <= '0;
            r_beat        <= '0;
            r_line        <= '0;
            r_bar_sub     <= '0;
            r_bar         <= '0;
            r_line_valid  <= 1'b0;
            r_data_valid  <= 1'b0;
            r_data        <= '0;
            r_frame_valid <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable_i) begin
                        r_state  <= S_V_BLANK;
                        r_sel    <= pattern_sel_i;
                        r_vb_cnt <= '0;
                        r_line   <= '0;
                    end
                end
                S_V_BLANK: begin
                    if (r_vb_cnt == c_vb_w'(V_BLANK - 1)) begin
                        r_state       <= S_LINE_LEAD;
                        r_line_valid  <= 1'b1;
                        r_frame_valid <= 1'b1;
                        r_frame_start <= 1'b1;
                        r_beat        <= '0;
                        r_bar         <= '0;
                        r_bar_sub     <= '0;
                    end else begin
                        r_vb_cnt <= r_vb_cnt + 1'b1;
                    end
                end
                S_LINE_LEAD, S_LINE_ACTIVE: begin
                    if (r_state == S_LINE_ACTIVE && r_beat == 12'(H_GROUPS)) begin
                        r_state      <= S_H_BLANK;
                        r_line_valid <= 1'b0;
                        r_data_valid <= 1'b0;
                        r_data       <= '0;
                        r_hb_cnt     <= '0;
                    end else begin
                        // The beat leaving here is the one shown in the next cycle.
                        r_state      <= S_LINE_ACTIVE;
                        r_data_valid <= 1'b1;
                        r_data       <= f_beat(r_sel, r_beat, r_bar, r_line[0]);
                        r_beat       <= r_beat + 1'b1;
                        if (r_bar_sub == 12'(BAR_GROUPS - 1)) begin
                            r_bar_sub <= '0;
                            if (r_bar != 3'd7) r_bar <= r_bar + 1'b1;
                        end else begin
                            r_bar_sub <= r_bar_sub + 1'b1;
                        end
                    end
                end
                S_H_BLANK: begin
                    if (r_hb_cnt == c_hb_w'(H_BLANK - 1)) begin
                        if (r_line == 12'(V_LINES - 1)) begin
                            r_frame_valid <= 1'b0;
                            r_frame_count <= r_frame_count + 1'b1;
                            r_line        <= '0;
                            if (enable_i) begin
                                r_state  <= S_V_BLANK;
                                r_sel    <= pattern_sel_i;
                                r_vb_cnt <= '0;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_state      <= S_LINE_LEAD;
                            r_line       <= r_line + 1'b1;
                            r_line_valid <= 1'b1;
                            r_beat       <= '0;
                            r_bar        <= '0;
                            r_bar_sub    <= '0;
                        end
                    end else begin
                        r_hb_cnt <= r_hb_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tx.line_valid   = r_line_valid;
    assign tx.data_valid   = r_data_valid;
    assign tx.data         = r_data;
    assign frame_valid_o   = r_frame_valid;
    assign frame_start_o   = r_frame_start;
    assign frame_count_o   = r_frame_count;
endmodule
`default_nettype wire

// File: tb/tb_bayer_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_bayer_pattern_tx
// Description : Scoreboard bench for bayer_pattern_tx with directed frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bayer_pattern_tx;
    localparam int          H_GROUPS   = 4;
    localparam int          V_LINES    = 4;
    localparam int          H_BLANK    = 3;
    localparam int          V_BLANK    = 5;
    localparam int          BAR_GROUPS = 1;
    localparam logic [15:0] PIXEL_MAX  = 16'h03FF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic        frame_valid;
    logic        frame_start;
    logic [15:0] frame_count;

    bayer_pattern_tx_if bus ();

    bayer_pattern_tx #(
        .H_GROUPS   (H_GROUPS),
        .V_LINES    (V_LINES),
        .H_BLANK    (H_BLANK),
        .V_BLANK    (V_BLANK),
        .BAR_GROUPS (BAR_GROUPS),
        .PIXEL_MAX  (PIXEL_MAX)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .enable_i      (enable),
        .pattern_sel_i (sel),
        .tx            (bus),
        .frame_valid_o (frame_valid),
        .frame_start_o (frame_start),
        .frame_count_o (frame_count)
    );

    always #5 clk = ~clk;

    // Hand-computed beats: bars with one beat per bar, ramp, grey.
    logic [63:0] bars_even [4] = '{64'h03FF_03FF_03FF_03FF, 64'h03FF_03FF_03FF_03FF,
                                   64'h0000_03FF_0000_03FF, 64'h0000_03FF_0000_03FF};
    logic [63:0] bars_odd  [4] = '{64'h03FF_03FF_03FF_03FF, 64'h03FF_0000_03FF_0000,
                                   64'h03FF_03FF_03FF_03FF, 64'h03FF_0000_03FF_0000};
    logic [63:0] ramp      [4] = '{64'h0000_0001_0002_0003, 64'h0004_0005_0006_0007,
                                   64'h0008_0009_000A_000B, 64'h000C_000D_000E_000F};
    logic [63:0] grey          = 64'h01FF_01FF_01FF_01FF;

    logic [63:0] exp_q [$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic push_frame(input int p);
        for (int l = 0; l < V_LINES; l++)
            for (int b = 0; b < H_GROUPS; b++)
                case (p)
                    0:       exp_q.push_back(l[0] ? bars_odd[b] : bars_even[b]);
                    1:       exp_q.push_back(ramp[b]);
                    default: exp_q.push_back(grey);
                endcase
    endtask

    always @(negedge clk) begin
        if (bus.data_valid) begin
            check("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check("beat_data", bus.data, exp_q.pop_front());
            check("lv_with_dv", 64'(bus.line_valid), 64'd1);
        end else begin
            check("data_zero_no_dv", bus.data, 64'd0);
        end
    end

    initial begin
        int fs_first, fs_n, fs_late, lv_n, dv_n, fv_n, lv_tail;
        fs_first = 0; fs_n = 0; fs_late = 0; lv_n = 0; dv_n = 0; fv_n = 0; lv_tail = 0;

        repeat (3) @(negedge clk);
        check("rst_line_valid",  64'(bus.line_valid), 64'd0);
        check("rst_data_valid",  64'(bus.data_valid), 64'd0);
        check("rst_frame_valid", 64'(frame_valid), 64'd0);
        check("rst_frame_start", 64'(frame_start), 64'd0);
        check("rst_frame_count", 64'(frame_count), 64'd0);

        // Three back-to-back frames: bars, ramp, grey; enable dropped in the third.
        reset = 1'b0; sel = 2'd0; enable = 1'b1;
        push_frame(0);
        for (int c = 1; c <= 140; c++) begin
            @(negedge clk);
            if (frame_start) begin
                fs_n++;
                if (fs_first == 0) fs_first = c;
                if (c >= 112) fs_late++;
            end
            if (c <= 37) begin
                lv_n += int'(bus.line_valid);
                dv_n += int'(bus.data_valid);
                fv_n += int'(frame_valid);
            end
            if (c >= 96 && c <= 111) lv_tail += int'(bus.line_valid);
            if (c == 6) begin
                check("lead_line_valid", 64'(bus.line_valid), 64'd1);
                check("lead_data_valid", 64'(bus.data_valid), 64'd0);
            end
            if (c == 20) begin sel = 2'd1; push_frame(1); end
            if (c == 37) check("count_before_end", 64'(frame_count), 64'd0);
            if (c == 38) begin
                check("count_frame1", 64'(frame_count), 64'd1);
                check("fv_after_frame1", 64'(frame_valid), 64'd0);
            end
            if (c == 45) begin sel = 2'd2; push_frame(2); end
            if (c == 75) check("count_frame2", 64'(frame_count), 64'd2);
            if (c == 90) enable = 1'b0;
            if (c == 112) check("count_frame3", 64'(frame_count), 64'd3);
        end
        check("first_frame_start", 64'(fs_first), 64'd6);
        check("frame_start_total", 64'(fs_n), 64'd3);
        check("no_start_in_idle", 64'(fs_late), 64'd0);
        check("line_valid_cycles", 64'(lv_n), 64'd20);
        check("data_valid_cycles", 64'(dv_n), 64'd16);
        check("frame_valid_cycles", 64'(fv_n), 64'd32);
        check("tail_lines_emitted", 64'(lv_tail), 64'd10);
        check("count_idle", 64'(frame_count), 64'd3);
        check("fv_idle", 64'(frame_valid), 64'd0);
        check("queue_drained_1", 64'(exp_q.size()), 64'd0);

        // Reset during line 1 of a bars frame.
        sel = 2'd0; enable = 1'b1;
        for (int b = 0; b < 4; b++) exp_q.push_back(bars_even[b]);
        exp_q.push_back(bars_odd[0]);
        exp_q.push_back(bars_odd[1]);
        for (int c = 1; c <= 16; c++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_line_valid",  64'(bus.line_valid), 64'd0);
        check("abort_data_valid",  64'(bus.data_valid), 64'd0);
        check("abort_data",        bus.data, 64'd0);
        check("abort_frame_valid", 64'(frame_valid), 64'd0);
        check("abort_frame_count", 64'(frame_count), 64'd0);
        check("queue_drained_2",   64'(exp_q.size()), 64'd0);

        // Restart: the fresh frame must begin on an even (R/G) line.
        reset = 1'b0;
        push_frame(0);
        fs_first = 0; fs_n = 0;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (frame_start) begin
                fs_n++;
                if (fs_first == 0) fs_first = c;
            end
            if (c == 10) enable = 1'b0;
            if (c == 37) check("restart_count_pre", 64'(frame_count), 64'd0);
            if (c == 38) check("restart_count", 64'(frame_count), 64'd1);
        end
        check("restart_first_start", 64'(fs_first), 64'd6);
        check("restart_start_total", 64'(fs_n), 64'd1);
        check("restart_count_idle", 64'(frame_count), 64'd1);
        check("queue_drained_3", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
